// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI master clock path.
// Mode encoding is {cpol,cpha}.
package spi_pkg;

   localparam int SPI_MAX_BITS = 32;

   typedef enum logic [1:0] {
      MODE0,
      MODE1,
      MODE2,
      MODE3
   } spi_mode_t;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      HOLD
   } sclk_state_t;

   function automatic int unsigned edge_count(input int unsigned nbits);
      return nbits << 1;
   endfunction

endpackage

// File: rtl/spi_baud_timer.sv
// Half-period timer: counts 0..div while enabled, pulses tc on div.
// load clears the count and wins over counting.
module spi_baud_timer #(
   parameter int DIV_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             en,
   input  logic [DIV_W-1:0] div,
   output logic             tc
);

   logic [DIV_W-1:0] cnt_q, cnt_d;

   assign tc = en && (cnt_q == div);

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = '0;
      end else if (tc) begin
         cnt_d = '0;
      end else if (en) begin
         cnt_d = cnt_q + DIV_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/spi_sclk_gen.sv
// SPI master sclk generator with load/shift/sample strobes and
// busy/done framing; config is latched when a frame starts.
module spi_sclk_gen
   import spi_pkg::*;
#(
   parameter int DIV_W    = 8,
   parameter int MAX_BITS = SPI_MAX_BITS,
   parameter int BITS_W   = $clog2(MAX_BITS + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic [DIV_W-1:0]  div,
   input  logic [BITS_W-1:0] nbits,
   input  logic              cpol,
   input  logic              cpha,
   output logic              sclk,
   output logic              load_stb,
   output logic              shift_stb,
   output logic              sample_stb,
   output logic              busy,
   output logic              done
);

   localparam logic [BITS_W-1:0] MAX_N = BITS_W'(MAX_BITS);

   sclk_state_t       state_q, state_d;
   logic [DIV_W-1:0]  div_q, div_d;
   logic              cpol_q, cpol_d;
   logic              cpha_q, cpha_d;
   logic [BITS_W:0]   edge_q, edge_d;
   logic              first_q, first_d;
   logic              sclk_q, sclk_d;
   logic              load_stb_q, load_stb_d;
   logic              shift_stb_q, shift_stb_d;
   logic              sample_stb_q, sample_stb_d;
   logic              done_q, done_d;

   logic              tmr_load, tmr_en, tc;
   logic [BITS_W-1:0] nbits_cl;
   logic              lead, last;
   spi_mode_t         mode;

   assign nbits_cl = (nbits > MAX_N) ? MAX_N : nbits;
   assign mode     = spi_mode_t'({cpol_q, cpha_q});
   // Edges count down from 2*nbits, so an even count is a leading edge.
   assign lead     = ~edge_q[0];
   assign last     = (edge_q == (BITS_W+1)'(1));

   spi_baud_timer #(
      .DIV_W (DIV_W)
   ) u_timer (
      .clk  (clk),
      .rst  (rst),
      .load (tmr_load),
      .en   (tmr_en),
      .div  (div_q),
      .tc   (tc)
   );

   always_comb begin
      state_d      = state_q;
      div_d        = div_q;
      cpol_d       = cpol_q;
      cpha_d       = cpha_q;
      edge_d       = edge_q;
      first_d      = first_q;
      sclk_d       = sclk_q;
      load_stb_d   = 1'b0;
      shift_stb_d  = 1'b0;
      sample_stb_d = 1'b0;
      done_d       = 1'b0;
      tmr_load     = 1'b0;
      tmr_en       = 1'b0;
      unique case (state_q)
         IDLE: begin
            sclk_d = cpol;
            if (start && !done_q && (nbits != '0)) begin
               state_d    = RUN;
               div_d      = div;
               cpol_d     = cpol;
               cpha_d     = cpha;
               edge_d     = (BITS_W+1)'(edge_count(32'(nbits_cl)));
               first_d    = 1'b1;
               load_stb_d = 1'b1;
               tmr_load   = 1'b1;
            end
         end
         RUN: begin
            if (abort) begin
               state_d  = IDLE;
               sclk_d   = cpol_q;
               tmr_load = 1'b1;
            end else begin
               tmr_en = 1'b1;
               if (tc) begin
                  sclk_d  = ~sclk_q;
                  first_d = 1'b0;
                  if (edge_q != '0) begin
                     edge_d = edge_q - (BITS_W+1)'(1);
                  end
                  unique case (mode)
                     MODE0, MODE2: begin
                        sample_stb_d = lead;
                        shift_stb_d  = ~lead && ~last;
                     end
                     MODE1, MODE3: begin
                        shift_stb_d  = lead && ~first_q;
                        sample_stb_d = ~lead;
                     end
                  endcase
                  if (last) begin
                     state_d = HOLD;
                  end
               end
            end
         end
         HOLD: begin
            if (abort) begin
               state_d  = IDLE;
               sclk_d   = cpol_q;
               tmr_load = 1'b1;
            end else begin
               tmr_en = 1'b1;
               if (tc) begin
                  state_d = IDLE;
                  sclk_d  = cpol_q;
                  done_d  = 1'b1;
               end
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         div_q        <= '0;
         cpol_q       <= 1'b0;
         cpha_q       <= 1'b0;
         edge_q       <= '0;
         first_q      <= 1'b0;
         sclk_q       <= 1'b0;
         load_stb_q   <= 1'b0;
         shift_stb_q  <= 1'b0;
         sample_stb_q <= 1'b0;
         done_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         div_q        <= div_d;
         cpol_q       <= cpol_d;
         cpha_q       <= cpha_d;
         edge_q       <= edge_d;
         first_q      <= first_d;
         sclk_q       <= sclk_d;
         load_stb_q   <= load_stb_d;
         shift_stb_q  <= shift_stb_d;
         sample_stb_q <= sample_stb_d;
         done_q       <= done_d;
      end
   end

   assign sclk       = sclk_q;
   assign load_stb   = load_stb_q;
   assign shift_stb  = shift_stb_q;
   assign sample_stb = sample_stb_q;
   assign done       = done_q;
   assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_spi_sclk_gen.sv
// Bench for spi_sclk_gen: directed frames with literal timing pins,
// then randomized frames against a cycle-offset reference model.
module tb_spi_sclk_gen;

   localparam int DIV_W    = 8;
   localparam int MAX_BITS = 32;
   localparam int BITS_W   = $clog2(MAX_BITS + 1);

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic              abort;
   logic [DIV_W-1:0]  div;
   logic [BITS_W-1:0] nbits;
   logic              cpol;
   logic              cpha;
   logic              sclk;
   logic              load_stb;
   logic              shift_stb;
   logic              sample_stb;
   logic              busy;
   logic              done;

   int ncmp = 0;
   int nerr = 0;
   int cyc  = 0;

   // frame statistics collected from the DUT
   int   smp, shf, ld_cyc, done_cyc, edge_cyc;
   logic prev_sclk = 1'b0;

   // reference model state: frame offset r, half period h, bits n
   bit   m_act   = 1'b0;
   int   m_r     = 0;
   int   m_h     = 1;
   int   m_n     = 0;
   bit   m_pol   = 1'b0;
   bit   m_pha   = 1'b0;
   bit   m_isclk = 1'b0;

   spi_sclk_gen #(
      .DIV_W    (DIV_W),
      .MAX_BITS (MAX_BITS),
      .BITS_W   (BITS_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .abort      (abort),
      .div        (div),
      .nbits      (nbits),
      .cpol       (cpol),
      .cpha       (cpha),
      .sclk       (sclk),
      .load_stb   (load_stb),
      .shift_stb  (shift_stb),
      .sample_stb (sample_stb),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      ncmp++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s cyc=%0d got=%0h want=%0h", nm, cyc, act, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic clr_stats();
      smp      = 0;
      shf      = 0;
      ld_cyc   = -1;
      done_cyc = -1;
      edge_cyc = -1;
   endtask

   // Per-cycle compare against the model, then advance the model using
   // the inputs the DUT will sample at the next rising edge.
   always @(negedge clk) begin
      int   rend, k;
      logic e_busy, e_done, e_load, e_sclk, e_smp, e_shf, edg, lead;
      rend   = 1 + (2 * m_n + 1) * m_h;
      e_busy = m_act && (m_r < rend);
      e_done = m_act && (m_r == rend);
      e_load = m_act && (m_r == 1);
      k      = m_act ? (m_r - 1) / m_h : 0;
      if (k > 2 * m_n) k = 2 * m_n;
      e_sclk = m_act ? (m_pol ^ k[0]) : m_isclk;
      edg    = e_busy && (m_r > 1) && (((m_r - 1) % m_h) == 0);
      lead   = k[0];
      e_smp  = edg && (m_pha ? !lead : lead);
      e_shf  = edg && (m_pha ? (lead && k != 1) : (!lead && k != 2 * m_n));
      if (rst) begin
         e_busy = 0; e_done = 0; e_load = 0;
         e_sclk = 0; e_smp  = 0; e_shf  = 0;
      end
      chk("sclk", 32'(sclk), 32'(e_sclk));
      chk("busy", 32'(busy), 32'(e_busy));
      chk("done", 32'(done), 32'(e_done));
      chk("load_stb", 32'(load_stb), 32'(e_load));
      chk("sample_stb", 32'(sample_stb), 32'(e_smp));
      chk("shift_stb", 32'(shift_stb), 32'(e_shf));

      if (sample_stb) smp++;
      if (shift_stb) shf++;
      if (load_stb) ld_cyc = cyc;
      if (done) done_cyc = cyc;
      if (sclk !== prev_sclk && edge_cyc < 0) edge_cyc = cyc;
      prev_sclk = sclk;

      if (rst) begin
         m_act   = 1'b0;
         m_isclk = 1'b0;
      end else if (e_busy && abort) begin
         m_act   = 1'b0;
         m_isclk = m_pol;
      end else if (e_busy) begin
         m_r++;
      end else begin
         m_isclk = cpol;
         if (start && !e_done && nbits != '0) begin
            m_act = 1'b1;
            m_r   = 1;
            m_h   = int'(div) + 1;
            m_n   = (int'(nbits) > MAX_BITS) ? MAX_BITS : int'(nbits);
            m_pol = cpol;
            m_pha = cpha;
         end else begin
            m_act = 1'b0;
         end
      end
   end

   task automatic frame(input int d, input int n, input logic p,
                        input logic h, output int t0);
      cpol  = p;
      cpha  = h;
      div   = DIV_W'(d);
      nbits = BITS_W'(n);
      step(3);
      clr_stats();
      start = 1'b1;
      t0    = cyc;
      step(1);
      start = 1'b0;
   endtask

   task automatic wait_idle();
      int g = 0;
      while (busy && g < 3000) begin
         step(1);
         g++;
      end
      chk("wait_idle_timeout", 32'(g >= 3000), 0);
      step(2);
   endtask

   initial begin
      int t0;
      rst   = 1'b1;
      start = 1'b0;
      abort = 1'b0;
      div   = '0;
      nbits = '0;
      cpol  = 1'b0;
      cpha  = 1'b0;
      clr_stats();
      step(2);
      chk("rst_sclk", 32'(sclk), 0);
      chk("rst_busy", 32'(busy), 0);
      chk("rst_strobes", 32'({load_stb, shift_stb, sample_stb, done}), 0);
      rst = 1'b0;
      step(2);

      // mode0, div=1, nbits=8
      frame(1, 8, 1'b0, 1'b0, t0);
      chk("m0_busy_t1", 32'(busy), 1);
      wait_idle();
      chk("m0_first_edge", 32'(edge_cyc), 32'(t0 + 3));
      chk("m0_load", 32'(ld_cyc), 32'(t0 + 1));
      chk("m0_samples", 32'(smp), 8);
      chk("m0_shifts", 32'(shf), 7);
      chk("m0_done", 32'(done_cyc), 32'(t0 + 35));

      // mode3, div=0, nbits=4
      frame(0, 4, 1'b1, 1'b1, t0);
      wait_idle();
      chk("m3_first_edge", 32'(edge_cyc), 32'(t0 + 2));
      chk("m3_samples", 32'(smp), 4);
      chk("m3_shifts", 32'(shf), 3);
      chk("m3_done", 32'(done_cyc), 32'(t0 + 10));

      // mode1 and mode2, div=3, nbits=1
      for (int m = 1; m <= 2; m++) begin
         logic p;
         p = (m == 2);
         frame(3, 1, p, ~p, t0);
         wait_idle();
         chk("n1_load", 32'(ld_cyc), 32'(t0 + 1));
         chk("n1_samples", 32'(smp), 1);
         chk("n1_shifts", 32'(shf), 0);
         chk("n1_done", 32'(done_cyc), 32'(t0 + 13));
         chk("n1_sclk_idle", 32'(sclk), 32'(p));
      end

      // abort at cycle 10 of a mode0 frame
      cpha = 1'b0;
      frame(1, 8, 1'b0, 1'b0, t0);
      step(9);
      abort = 1'b1;
      step(1);
      abort = 1'b0;
      chk("abort_busy", 32'(busy), 0);
      chk("abort_sclk", 32'(sclk), 0);
      step(40);
      chk("abort_no_done", 32'(done_cyc), 32'(-1));
      chk("abort_samples", 32'(smp), 2);
      chk("abort_shifts", 32'(shf), 2);

      // stray starts mid-frame, in the done cycle, and with nbits=0
      frame(1, 8, 1'b0, 1'b0, t0);
      step(4);
      start = 1'b1;
      nbits = BITS_W'(3);
      step(1);
      start = 1'b0;
      step(29);
      start = 1'b1;
      step(1);
      nbits = '0;
      step(1);
      start = 1'b0;
      chk("ign_busy", 32'(busy), 0);
      step(2);
      chk("ign_samples", 32'(smp), 8);
      chk("ign_done", 32'(done_cyc), 32'(t0 + 35));

      // asynchronous reset mid-frame, then a clamped frame
      frame(1, 8, 1'b0, 1'b0, t0);
      step(3);
      chk("pre_rst_sclk", 32'(sclk), 1);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_sclk", 32'(sclk), 0);
      chk("async_rst_busy", 32'(busy), 0);
      step(2);
      rst = 1'b0;
      step(1);
      frame(0, MAX_BITS + 5, 1'b0, 1'b0, t0);
      wait_idle();
      chk("clamp_samples", 32'(smp), 32'(MAX_BITS));
      chk("clamp_shifts", 32'(shf), 32'(MAX_BITS - 1));
      chk("clamp_done", 32'(done_cyc), 32'(t0 + 2 + 2 * MAX_BITS));

      // randomized frames with junk inputs while busy
      for (int f = 0; f < 30; f++) begin
         int g, n;
         n = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, MAX_BITS + 5))
                                         : int'($urandom_range(0, 6));
         div   = DIV_W'($urandom_range(0, 4));
         nbits = BITS_W'(n);
         cpol  = 1'($urandom_range(0, 1));
         cpha  = 1'($urandom_range(0, 1));
         step(int'($urandom_range(1, 3)));
         start = 1'b1;
         step(1);
         start = 1'b0;
         g = 0;
         while (busy && g < 3000) begin
            start = ($urandom_range(0, 7) == 0);
            abort = ($urandom_range(0, 149) == 0);
            div   = DIV_W'($urandom_range(0, 9));
            nbits = BITS_W'($urandom_range(0, MAX_BITS + 5));
            cpol  = 1'($urandom_range(0, 1));
            cpha  = 1'($urandom_range(0, 1));
            step(1);
            g++;
         end
         start = 1'b0;
         abort = 1'b0;
         chk("rand_timeout", 32'(g >= 3000), 0);
         repeat ($urandom_range(0, 3)) begin
            abort = 1'($urandom_range(0, 1));
            cpol  = 1'($urandom_range(0, 1));
            step(1);
         end
         abort = 1'b0;
      end
      step(3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
      $finish;
   end

endmodule
